// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction timer: FSM states, BCD digit type,
// blank code and the LFSR seed/taps used for the random pre-GO wait.
package rt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t      BCD_BLANK = 4'hF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps at positions 16, 14, 13 and 11 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter for the live reaction count. Resets to the blank code;
// blank overrides clear, clear overrides increment.
module bcd_digit
    import rt_pkg::*;
(
    input  logic   CLK,
    input  logic   RST_N,
    input  logic   clr,
    input  logic   blank,
    input  logic   inc,
    output digit_t q,
    output logic   carry
);

    digit_t digit_q;
    digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (blank) begin
            digit_d = BCD_BLANK;
        end else if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            digit_q <= BCD_BLANK;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q     = digit_q;
    assign carry = inc & (digit_q == 4'd9);

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer measurement engine: random wait, GO lamp, ms BCD count, best score.
// Optional false-start detection is built when RT_FALSE_START_EN is defined.
//
// state | meaning
// IDLE  | after reset, no round played yet
// ARMED | random pre-GO wait counting down in ms
// RUN   | GO lamp on, live count incrementing every ms
// DONE  | count frozen (stop or saturation), best score compared once
// FAULT | stop pressed before GO (false-start build only)
module reaction_timer_core
    import rt_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int NDIG         = 4,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    output logic [4*NDIG-1:0] BCD,
    output logic [4*NDIG-1:0] HIGH,
    output logic              LED,
    output logic              EN,
    output logic              TOO_SOON,
    output logic              OVERFLOW
);

    localparam int TC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY_MS + 2**RAND_BITS) + 1;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TC_W-1:0]    tick_q, tick_d;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [4*NDIG-1:0]  high_q, high_d;
    logic               led_q, led_d;
    logic               en_q, en_d;
    logic               ovf_q, ovf_d;
    logic               cmp_q, cmp_d;

    logic [4*NDIG-1:0]  bcd_w;
    logic [NDIG-1:0]    dig_inc;
    logic [NDIG-1:0]    dig_carry;
    logic               dig_clr;
    logic               dig_blank;
    logic               inc0;
    logic               tick;
    logic               all9;
    logic               bcd_lt;
    logic               decided;
    logic               unused_carry;

`ifdef RT_FALSE_START_EN
    logic               ts_q, ts_d;
`endif

    assign tick         = (tick_q == TC_W'(TICK_DIV - 1));
    assign all9         = (bcd_w == {NDIG{4'h9}});
    assign unused_carry = dig_carry[NDIG-1];

    // Packed BCD compare from the most significant digit down.
    always_comb begin
        bcd_lt  = 1'b0;
        decided = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (!decided && (bcd_w[4*i +: 4] != high_q[4*i +: 4])) begin
                decided = 1'b1;
                bcd_lt  = (bcd_w[4*i +: 4] < high_q[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_next(lfsr_q);
        tick_d    = tick_q;
        delay_d   = delay_q;
        high_d    = high_q;
        led_d     = led_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        cmp_d     = 1'b0;
        dig_clr   = 1'b0;
        dig_blank = 1'b0;
        inc0      = 1'b0;
`ifdef RT_FALSE_START_EN
        ts_d      = ts_q;
`endif

        if (state_q == ST_ARMED || state_q == ST_RUN) begin
            tick_d = tick ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            ST_ARMED: begin
`ifdef RT_FALSE_START_EN
                if (STOP) begin
                    state_d   = ST_FAULT;
                    ts_d      = 1'b1;
                    dig_blank = 1'b1;
                    led_d     = 1'b0;
                    en_d      = 1'b0;
                end else
`endif
                if (tick) begin
                    if (delay_q <= DLY_W'(1)) begin
                        state_d = ST_RUN;
                        led_d   = 1'b1;
                        en_d    = 1'b1;
                        tick_d  = '0;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Stop beats a coincident tick so the shown time is what was seen.
                if (STOP) begin
                    state_d = ST_DONE;
                    led_d   = 1'b0;
                    cmp_d   = 1'b1;
                end else if (tick) begin
                    if (all9) begin
                        state_d = ST_DONE;
                        led_d   = 1'b0;
                        ovf_d   = 1'b1;
                        cmp_d   = 1'b1;
                    end else begin
                        inc0 = 1'b1;
                    end
                end
            end
            default: begin
                if (START) begin
                    state_d = ST_ARMED;
                    dig_clr = 1'b1;
                    ovf_d   = 1'b0;
                    led_d   = 1'b0;
                    en_d    = 1'b0;
                    tick_d  = '0;
                    delay_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
`ifdef RT_FALSE_START_EN
                    ts_d    = 1'b0;
`endif
                end
            end
        endcase

        // First DONE cycle: keep the lower score; a saturated count never qualifies.
        if (cmp_q && !ovf_q && ((high_q == '1) || bcd_lt)) begin
            high_d = bcd_w;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            tick_q  <= '0;
            delay_q <= '0;
            high_q  <= {NDIG{BCD_BLANK}};
            led_q   <= 1'b0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cmp_q   <= 1'b0;
`ifdef RT_FALSE_START_EN
            ts_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            delay_q <= delay_d;
            high_q  <= high_d;
            led_q   <= led_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            cmp_q   <= cmp_d;
`ifdef RT_FALSE_START_EN
            ts_q    <= ts_d;
`endif
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        if (g == 0) begin : g_lsd
            assign dig_inc[g] = inc0;
        end else begin : g_upper
            assign dig_inc[g] = dig_carry[g-1];
        end

        bcd_digit u_dig (
            .CLK   (CLK),
            .RST_N (RST_N),
            .clr   (dig_clr),
            .blank (dig_blank),
            .inc   (dig_inc[g]),
            .q     (bcd_w[4*g +: 4]),
            .carry (dig_carry[g])
        );
    end

    assign BCD      = bcd_w;
    assign HIGH     = high_q;
    assign LED      = led_q;
    assign EN       = en_q;
    assign OVERFLOW = ovf_q;
`ifdef RT_FALSE_START_EN
    assign TOO_SOON = ts_q;
`else
    assign TOO_SOON = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reaction_timer_core;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        STOP  = 1'b0;
    logic [15:0] BCD;
    logic [15:0] HIGH;
    logic        LED;
    logic        EN;
    logic        TOO_SOON;
    logic        OVERFLOW;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [15:0] high;
        logic        led;
        logic        en;
        logic        ts;
        logic        ov;
    } exp_t;

    exp_t  sbq[$];
    string nameq[$];

    reaction_timer_core #(
        .TICK_DIV     (4),
        .NDIG         (4),
        .MIN_DELAY_MS (2),
        .RAND_BITS    (2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .STOP     (STOP),
        .BCD      (BCD),
        .HIGH     (HIGH),
        .LED      (LED),
        .EN       (EN),
        .TOO_SOON (TOO_SOON),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_at(input string nm, input int c, input logic [15:0] b,
                             input logic [15:0] h, input logic l, input logic e,
                             input logic t, input logic o);
        exp_t x;
        x.cyc  = c;
        x.bcd  = b;
        x.high = h;
        x.led  = l;
        x.en   = e;
        x.ts   = t;
        x.ov   = o;
        sbq.push_back(x);
        nameq.push_back(nm);
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", nm, cyc);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step(1);
        START = 1'b0;
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        step(1);
        STOP = 1'b0;
    endtask

    task automatic wait_led(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (LED) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (!ok) timeout_fail(nm);
    endtask

    // One round: GO seen at cycle E, count increments at E+4k. A normal stop lands
    // mid-period; a coincident stop lands exactly on the (n+1)th tick edge.
    task automatic play(input string nm, input int n, input bit coinc,
                        input logic [15:0] exp_bcd, input logic [15:0] h_before,
                        input logic [15:0] h_after);
        bit ok;
        int s;
        pulse_start();
        expect_at({nm, "_armed"}, cyc, 16'h0000, h_before, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_led({nm, "_go"}, ok);
        if (ok) begin
            step(coinc ? 4 * (n + 1) - 1 : 4 * n + 1);
            pulse_stop();
            s = cyc;
            expect_at({nm, "_stop"}, s,     exp_bcd, h_before, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_at({nm, "_high"}, s + 1, exp_bcd, h_after,  1'b0, 1'b1, 1'b0, 1'b0);
            step(3);
        end
    endtask

    initial begin : monitor
        exp_t  x;
        string nm;
        forever begin
            @(negedge CLK);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                x  = sbq.pop_front();
                nm = nameq.pop_front();
                n_chk++;
                if (x.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cycle %0d missed, now at cycle %0d", nm, x.cyc, cyc);
                end else if ({BCD, HIGH, LED, EN, TOO_SOON, OVERFLOW} !==
                             {x.bcd, x.high, x.led, x.en, x.ts, x.ov}) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got bcd=%h high=%h led=%b en=%b ts=%b ov=%b, expected bcd=%h high=%h led=%b en=%b ts=%b ov=%b",
                             nm, cyc, BCD, HIGH, LED, EN, TOO_SOON, OVERFLOW,
                             x.bcd, x.high, x.led, x.en, x.ts, x.ov);
                end
            end
        end
    end

    initial begin : stimulus
        bit ok;
        int e;

        step(3);
        expect_at("rst_hold", cyc, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        step(1);
        expect_at("rst_idle", cyc, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);

        play("r37", 37, 1'b0, 16'h0037, 16'hFFFF, 16'h0037);
        play("r52", 52, 1'b0, 16'h0052, 16'h0037, 16'h0037);
        play("r09",  9, 1'b0, 16'h0009, 16'h0037, 16'h0009);

        pulse_start();
        expect_at("fs_armed", cyc, 16'h0000, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        pulse_stop();
`ifdef RT_FALSE_START_EN
        expect_at("fs_fault", cyc,     16'hFFFF, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_at("fs_hold",  cyc + 3, 16'hFFFF, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5);
`else
        expect_at("fs_ignored", cyc, 16'h0000, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_led("fs_go", ok);
        if (ok) begin
            expect_at("fs_run", cyc, 16'h0000, 16'h0009, 1'b1, 1'b1, 1'b0, 1'b0);
            step(4 * 12 + 1);
            pulse_stop();
            expect_at("fs_stop", cyc,     16'h0012, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_at("fs_high", cyc + 1, 16'h0012, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0);
            step(3);
        end
`endif

        play("c99", 99, 1'b1, 16'h0099, 16'h0009, 16'h0009);

        pulse_start();
        expect_at("sat_armed", cyc, 16'h0000, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_led("sat_go", ok);
        if (ok) begin
            e = cyc;
            expect_at("sat_pre",     e + 39999, 16'h9999, 16'h0009, 1'b1, 1'b1, 1'b0, 1'b0);
            expect_at("sat_ovf",     e + 40000, 16'h9999, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b1);
            expect_at("sat_nostore", e + 40001, 16'h9999, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b1);
            expect_at("sat_hold",    e + 40006, 16'h9999, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b1);
            step(40008);
        end
        pulse_start();
        expect_at("sat_clear", cyc, 16'h0000, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_led("rst_go", ok);
        step(10);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        expect_at("midrun_rst", cyc, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        expect_at("post_rst", cyc, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) step(1);
        if (sbq.size() > 0) timeout_fail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
- Measurement engine for the reaction timer; sits directly upstream of the per-digit BCD-to-7-segment decoders.
- Runs the game sequence: random wait, GO lamp, millisecond BCD count, stop.
- Keeps the best (lowest) score.
- Drives the packed digits BCD (live), HIGH (best), the LED/EN qualifiers and a fault flag; each 4-bit slice feeds one decoder instance.

Parameters:
- TICK_DIV, 50000, CLK cycles per 1 ms tick (50 MHz clock); the bench uses a small value such as 4.
- NDIG, 4, number of BCD digits (max count 10^NDIG - 1 ms).
- MIN_DELAY_MS, 1000, fixed part of the random pre-GO wait, in ms.
- RAND_BITS, 11, width of the random wait addend (0..2^RAND_BITS - 1 ms).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset, sampled on the rising CLK edge.
- START  in  1  single-cycle debounced pulse: begin a round.
- STOP  in  1  single-cycle debounced pulse: player reaction.
- BCD  out  4*NDIG  live count; digit i at [4i+3:4i]; 4'hF = blank.
- HIGH  out  4*NDIG  best score, same packing; all 4'hF = no score yet.
- LED  out  1  GO lamp; high only in RUN.
- EN  out  1  high in RUN and DONE: live count valid.
- TOO_SOON  out  1  high in FAULT.
- OVERFLOW  out  1  sticky, set when the count saturates; cleared by START.

Behaviour:
- Reset (RST_N=0 at a CLK edge): state=IDLE, BCD all 4'hF, HIGH all 4'hF, LED=EN=TOO_SOON=OVERFLOW=0, tick counter=0, delay=0.
- The LFSR reseeds to 16'hACE1 on reset, then free-runs every cycle regardless of state.
- Reset wins over every other input in the same cycle, mid-round included.
- All outputs are registered.
- States: IDLE, ARMED, RUN, DONE, FAULT.
- IDLE/DONE/FAULT + START:
  - Next cycle: ARMED, BCD all 0, OVERFLOW=0, TOO_SOON=0.
  - Load delay = MIN_DELAY_MS + LFSR[RAND_BITS-1:0].
  - Clear the tick counter.
- START in ARMED or RUN is ignored.
- ARMED: delay decrements on each ms tick. Tick = tick counter reaching TICK_DIV-1, then it wraps to 0.
- ARMED, tick with delay==1: next cycle RUN, LED=1, EN=1, tick counter cleared so the first counted ms is full length.
- ARMED + STOP: see optional feature.
- RUN, each tick: BCD increments as a decimal ripple; digit 9 wraps to 0 with carry into the next digit.
- RUN, at all digits 9: no wrap. BCD holds at all 9s, OVERFLOW=1, next cycle DONE.
- RUN + STOP: next cycle DONE, LED=0, BCD frozen.
- STOP and tick in the same cycle: STOP wins and the increment is discarded.
- DONE entry: comparison happens in the first DONE cycle; HIGH updates one cycle later.
  - If HIGH is all 4'hF, or the BCD value is numerically less than HIGH, HIGH <= BCD.
  - Compare is digit-wise from the MSD.
  - An overflowed result is never stored.
- DONE holds until START.
- FAULT: LED=0, EN=0, TOO_SOON=1, BCD all 4'hF; holds until START.
- Latency:
  - START to ARMED: 1 cycle.
  - STOP to LED low: 1 cycle.
  - STOP to HIGH valid: 2 cycles.

Optional Feature:
- Macro: RT_FALSE_START_EN.
- Defined: STOP in ARMED goes to FAULT next cycle; HIGH is unchanged.
- Undefined: STOP in ARMED is ignored and the FAULT state and TOO_SOON logic are not generated; TOO_SOON is tied to 0.

Decomposition:
- Package rt_pkg:
  - State enum.
  - BCD_BLANK = 4'hF.
  - LFSR_SEED = 16'hACE1.
  - LFSR taps (16, 14, 13, 11).
  - Digit typedef (logic [3:0]).
- Sub-module bcd_digit: one decade counter.
  - Inputs: CLK, RST_N, clr, inc.
  - Outputs: q[3:0], carry.
  - carry = inc & (q==9).
  - Instantiated NDIG times with a ripple carry.
- The LFSR, tick divider, FSM and best-score compare stay in reaction_timer_core.

Test Plan (TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2):
- Reset release → BCD=HIGH=16'hFFFF, LED=EN=TOO_SOON=OVERFLOW=0, state IDLE.
- START; wait for LED=1; STOP after 37 ticks → BCD=16'h0037, LED=0 next cycle, HIGH=16'h0037 two cycles after STOP.
- Second round stopped at 52 ticks → HIGH stays 16'h0037. Third round stopped at 9 ticks → HIGH=16'h0009.
- STOP during ARMED:
  - RT_FALSE_START_EN defined → TOO_SOON=1, BCD=16'hFFFF, HIGH unchanged.
  - Undefined → ignored; LED still rises.
- Never press STOP → BCD saturates at 16'h9999, OVERFLOW=1, DONE, HIGH unchanged. Next START clears OVERFLOW and BCD=16'h0000.
- STOP coincident with a tick at count 0099 → BCD=16'h0099, not 0100.
- RST_N low for one cycle mid-RUN → all outputs at reset values the following cycle.
